// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multipliers.
// The digit decode here is common to the sequential and the future parallel datapath.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // One radix-4 Booth digit as sign/magnitude: value = (sign ? -1 : +1) * (two ? 2 : one).
    typedef struct packed {
        logic sign;
        logic two;
        logic one;
    } digit_t;

    function automatic int unsigned booth_digits(int unsigned width);
        return width / 2 + 1;
    endfunction

    // g = {B[2i+1], B[2i], B[2i-1]}; 111 and 000 both decode to zero.
    function automatic digit_t booth_decode(logic [2:0] g);
        digit_t d;
        d.sign = g[2] & ~(g[1] & g[0]);
        d.one  = g[1] ^ g[0];
        d.two  = (g == 3'b011) | (g == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for the Booth multiplier.
// master drives operands and accepts results; slave is the multiplier.
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/booth_digit_pp.sv
// Combinational radix-4 Booth partial product: pp = digit(g) * a.
// The output is wide enough that -2 * (most negative a) does not overflow.
module booth_digit_pp
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]              g,
    input  logic [WIDTH+1:0]        a,
    output logic signed [WIDTH+2:0] pp
);
    digit_t            d;
    logic [WIDTH+2:0]  a_ext;
    logic [WIDTH+2:0]  mag;

    assign d     = booth_decode(g);
    assign a_ext = {a[WIDTH+1], a};

    always_comb begin
        mag = '0;
        if (d.one) begin
            mag = a_ext;
        end else if (d.two) begin
            mag = a_ext << 1;
        end
        pp = d.sign ? (~mag + {{(WIDTH+2){1'b0}}, 1'b1}) : mag;
    end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier retiring one digit per cycle behind valid/ready.
// Signed/unsigned mode is chosen per operation by how the operands are extended at capture.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    booth_mult_seq_if.slave bus
);
    localparam int unsigned DIGITS = booth_digits(WIDTH);
    localparam int unsigned EW     = WIDTH + 2;
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned SW     = $clog2(DIGITS);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("booth_mult_seq: WIDTH must be even and >= 4");
    end

    state_e            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [PW-1:0]     out_p_q;
    logic [EW-1:0]     a_q;
    logic [EW:0]       b_q;     // extended multiplier with the implicit B[-1] at bit 0
    logic [PW-1:0]     acc_q;
    logic [SW-1:0]     step_q;

    logic signed [WIDTH+2:0] pp;
    logic [PW-1:0]           pp_shift;
    logic [PW-1:0]           acc_next;

    function automatic logic [EW-1:0] extend(logic [WIDTH-1:0] x, logic s);
        return {{2{s & x[WIDTH-1]}}, x};
    endfunction

    booth_digit_pp #(
        .WIDTH (WIDTH)
    ) u_digit_pp (
        .g  (b_q[2:0]),
        .a  (a_q),
        .pp (pp)
    );

    assign pp_shift = {{(PW-WIDTH-3){pp[WIDTH+2]}}, pp} << {step_q, 1'b0};
    assign acc_next = acc_q + pp_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            step_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= extend(bus.in_a, bus.in_signed);
                        b_q        <= {extend(bus.in_b, bus.in_signed), 1'b0};
                        acc_q      <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    acc_q  <= acc_next;
                    b_q    <= b_q >> 2;
                    step_q <= step_q + SW'(1);
                    if (step_q == SW'(DIGITS - 1)) begin
                        out_p_q     <= acc_next;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks of booth_mult_seq at WIDTH 4, 8 and 16.
// Expected products come from an integer golden model via per-width scoreboard queues.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(4))  bus4 ();
    booth_mult_seq_if #(.WIDTH(8))  bus8 ();
    booth_mult_seq_if #(.WIDTH(16)) bus16 ();

    booth_mult_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    booth_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    booth_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb4[$];
    logic [31:0] sb8[$];
    logic [31:0] sb16[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden(int w, logic [15:0] a, logic [15:0] b, logic s);
        longint mask, ax, bx;
        mask = (longint'(1) << w) - 1;
        ax = longint'(a) & mask;
        bx = longint'(b) & mask;
        if (s && a[w-1]) ax = ax - (longint'(1) << w);
        if (s && b[w-1]) bx = bx - (longint'(1) << w);
        return 32'((ax * bx) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic set_in(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic s);
        case (w)
            4: begin bus4.in_valid = v; bus4.in_a = a[3:0]; bus4.in_b = b[3:0];
                     bus4.in_signed = s; end
            8: begin bus8.in_valid = v; bus8.in_a = a[7:0]; bus8.in_b = b[7:0];
                     bus8.in_signed = s; end
            default: begin bus16.in_valid = v; bus16.in_a = a; bus16.in_b = b;
                     bus16.in_signed = s; end
        endcase
    endtask

    task automatic set_ready(input int w, input logic r);
        case (w)
            4: bus4.out_ready = r;
            8: bus8.out_ready = r;
            default: bus16.out_ready = r;
        endcase
    endtask

    function automatic logic get_valid(int w);
        case (w)
            4: return bus4.out_valid;
            8: return bus8.out_valid;
            default: return bus16.out_valid;
        endcase
    endfunction

    function automatic logic get_ready(int w);
        case (w)
            4: return bus4.in_ready;
            8: return bus8.in_ready;
            default: return bus16.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_p(int w);
        case (w)
            4: return 32'(bus4.out_p);
            8: return 32'(bus8.out_p);
            default: return 32'(bus16.out_p);
        endcase
    endfunction

    task automatic push(input int w, input logic [31:0] v);
        case (w)
            4: sb4.push_back(v);
            8: sb8.push_back(v);
            default: sb16.push_back(v);
        endcase
    endtask

    task automatic pop(input int w, output logic ok, output logic [31:0] v);
        ok = 1'b0; v = '0;
        case (w)
            4: if (sb4.size() > 0) begin v = sb4.pop_front(); ok = 1'b1; end
            8: if (sb8.size() > 0) begin v = sb8.pop_front(); ok = 1'b1; end
            default: if (sb16.size() > 0) begin v = sb16.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Presents one operand pair; returns at the falling edge after the accept edge.
    task automatic start_op(input int w, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input string tag);
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(get_ready(w)), 32'd1);
        set_in(w, 1'b1, a, b, s);
        push(w, golden(w, a, b, s));
        @(posedge clk);
        @(negedge clk);
        set_in(w, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    // Waits for the result, checks latency/product, stalls, then releases it.
    task automatic finish_op(input int w, input int stall, input bit pulse, input string tag);
        int lat;
        logic rdy_seen, ok;
        logic [31:0] exp;
        lat = 0;
        rdy_seen = get_ready(w);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (get_valid(w)) begin
                lat = n;
                break;
            end
            rdy_seen |= get_ready(w);
        end
        check({tag, " latency"}, 32'(lat), 32'(w / 2 + 1));
        check({tag, " in_ready low while busy"}, 32'(rdy_seen), 32'd0);
        if (lat == 0) return;
        pop(w, ok, exp);
        check({tag, " result expected"}, 32'(ok), 32'd1);
        check({tag, " out_p"}, get_p(w), exp);
        for (int k = 0; k < stall; k++) begin
            if (pulse) set_in(w, 1'b1, 16'h0003, 16'h0005, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check({tag, " held valid"}, 32'(get_valid(w)), 32'd1);
            check({tag, " held out_p"}, get_p(w), exp);
        end
        set_in(w, 1'b0, 16'h0, 16'h0, 1'b0);
        set_ready(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(w, 1'b0);
        check({tag, " released valid"}, 32'(get_valid(w)), 32'd0);
        check({tag, " released in_ready"}, 32'(get_ready(w)), 32'd1);
        check({tag, " out_p kept after release"}, get_p(w), exp);
    endtask

    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                          input int stall, input bit pulse, input string tag);
        start_op(w, a, b, s, tag);
        finish_op(w, stall, pulse, tag);
    endtask

    initial begin
        int ws[3];
        int st;
        logic [15:0] a, b;
        logic quiet;
        ws[0] = 4; ws[1] = 8; ws[2] = 16;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(ws[i], 1'b0, 16'h0, 16'h0, 1'b0);
            set_ready(ws[i], 1'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("reset in_ready", 32'(get_ready(ws[i])), 32'd1);
            check("reset out_valid", 32'(get_valid(ws[i])), 32'd0);
            check("reset out_p", get_p(ws[i]), 32'd0);
        end

        // Directed checks with hand-computed products.
        run_op(8, 16'h0003, 16'h00FB, 1'b1, 0, 1'b0, "3*-5");
        check("3*-5 const", get_p(8), 32'h0000_FFF1);
        run_op(8, 16'h0080, 16'h0080, 1'b1, 1, 1'b0, "-128*-128");
        check("-128*-128 const", get_p(8), 32'h0000_4000);
        run_op(8, 16'h0080, 16'h007F, 1'b1, 0, 1'b0, "-128*127");
        check("-128*127 const", get_p(8), 32'h0000_C080);
        run_op(8, 16'h007F, 16'h007F, 1'b1, 0, 1'b0, "127*127");
        check("127*127 const", get_p(8), 32'h0000_3F01);
        run_op(8, 16'h00FF, 16'h00FF, 1'b0, 0, 1'b0, "ff*ff unsigned");
        check("ff*ff unsigned const", get_p(8), 32'h0000_FE01);
        run_op(8, 16'h00FF, 16'h00FF, 1'b1, 0, 1'b0, "ff*ff signed");
        check("ff*ff signed const", get_p(8), 32'h0000_0001);

        // Backpressure with in_valid pulsed during DONE; nothing may be captured.
        run_op(8, 16'h0007, 16'h0006, 1'b0, 10, 1'b1, "backpressure 7*6");
        check("backpressure const", get_p(8), 32'h0000_002A);
        check("no capture during DONE", 32'(sb8.size()), 32'd0);
        quiet = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            quiet |= get_valid(8);
        end
        check("no spurious result after backpressure", 32'(quiet), 32'd0);

        // Reset in the second BUSY cycle aborts the operation.
        start_op(8, 16'h0007, 16'h0006, 1'b0, "abort");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        void'(sb8.pop_back());
        check("abort in_ready", 32'(get_ready(8)), 32'd1);
        check("abort out_valid", 32'(get_valid(8)), 32'd0);
        check("abort out_p", get_p(8), 32'd0);
        quiet = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            quiet |= get_valid(8);
        end
        check("abort no partial result", 32'(quiet), 32'd0);
        run_op(8, 16'h0000, 16'h00FF, 1'b1, 0, 1'b0, "0*-1 after abort");
        check("0*-1 const", get_p(8), 32'h0000_0000);
        run_op(8, 16'h0007, 16'h0006, 1'b0, 0, 1'b0, "7*6 after abort");
        check("7*6 const", get_p(8), 32'h0000_002A);

        // Random operations in both modes with short result stalls.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 1500; n++) begin
                case ($urandom_range(0, 9))
                    0: a = 16'h0000;
                    1: a = 16'hFFFF;
                    2: a = 16'h0001 << (ws[i] - 1);
                    default: a = 16'($urandom);
                endcase
                case ($urandom_range(0, 9))
                    0: b = 16'h0000;
                    1: b = 16'hFFFF;
                    2: b = 16'h0001 << (ws[i] - 1);
                    default: b = 16'($urandom);
                endcase
                st = $urandom_range(0, 2);
                run_op(ws[i], a, b, 1'($urandom_range(0, 1)), st, 1'b0, $sformatf("rand w%0d", ws[i]));
            end
        end
        check("scoreboard w4 drained", 32'(sb4.size()), 32'd0);
        check("scoreboard w8 drained", 32'(sb8.size()), 32'd0);
        check("scoreboard w16 drained", 32'(sb16.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
